// File: rtl/per2axi_arbiter.sv
// per2axi_arbiter: round-robin N:1 peripheral arbiter in front of a per2axi bridge.
// It locks on a stalled winner, tags IDs with the requester index and limits outstanding transactions per requester.
module per2axi_arbiter #(
  parameter int NB_REQ     = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 5,
  parameter int MAX_OUTST  = 4,
  parameter int IDX_W      = $clog2(NB_REQ)
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NB_REQ-1:0]                 s_req_i,
  input  logic [NB_REQ*ADDR_WIDTH-1:0]      s_add_i,
  input  logic [NB_REQ-1:0]                 s_we_n_i,
  input  logic [NB_REQ*DATA_WIDTH-1:0]      s_wdata_i,
  input  logic [NB_REQ*(DATA_WIDTH/8)-1:0]  s_be_i,
  input  logic [NB_REQ*ID_WIDTH-1:0]        s_id_i,
  output logic [NB_REQ-1:0]                 s_gnt_o,
  output logic [NB_REQ-1:0]                 s_r_valid_o,
  output logic                              s_r_opc_o,
  output logic [ID_WIDTH-1:0]               s_r_id_o,
  output logic [DATA_WIDTH-1:0]             s_r_rdata_o,
  output logic                              m_req_o,
  output logic [ADDR_WIDTH-1:0]             m_add_o,
  output logic                              m_we_n_o,
  output logic [DATA_WIDTH-1:0]             m_wdata_o,
  output logic [DATA_WIDTH/8-1:0]           m_be_o,
  output logic [IDX_W+ID_WIDTH-1:0]         m_id_o,
  input  logic                              m_gnt_i,
  input  logic                              m_r_valid_i,
  input  logic                              m_r_opc_i,
  input  logic [IDX_W+ID_WIDTH-1:0]         m_r_id_i,
  input  logic [DATA_WIDTH-1:0]             m_r_rdata_i,
  output logic                              busy_o,
  output logic                              err_o
);
  localparam int CNT_W = $clog2(MAX_OUTST) + 1;
  localparam int BE_W  = DATA_WIDTH / 8;
  typedef enum logic {ARB, LOCK} state_e;
  state_e               state_q, state_d;
  logic [IDX_W-1:0]     rr_q, rr_d, lock_q, lock_d, win, r_idx;
  logic [CNT_W-1:0]     outst_q [NB_REQ];
  logic [CNT_W-1:0]     outst_d [NB_REQ];
  logic [NB_REQ-1:0]    elig;
  logic                 found, req, hs, r_ok, err_q;
  always_comb begin
    for (int k = 0; k < NB_REQ; k++) elig[k] = s_req_i[k] && (outst_q[k] < CNT_W'(MAX_OUTST));
  end
  // In LOCK the winner is frozen; in ARB search upward from rr_q with wrap-around.
  always_comb begin
    found = 1'b0;
    win   = lock_q;
    if (state_q == ARB)
      for (int i = 0; i < NB_REQ; i++)
        if (!found && elig[(int'(rr_q) + i) % NB_REQ]) begin
          found = 1'b1;
          win   = IDX_W'((int'(rr_q) + i) % NB_REQ);
        end
  end
  assign req = (state_q == ARB) ? found : s_req_i[win];
  assign hs  = req & m_gnt_i;
  always_comb begin
    state_d = (req && !m_gnt_i) ? LOCK : ARB;
    lock_d  = (req && !m_gnt_i) ? win : lock_q;
    rr_d    = hs ? IDX_W'((int'(win) + 1) % NB_REQ) : rr_q;
  end
  assign m_req_o   = req;
  assign m_add_o   = req ? s_add_i[int'(win)*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  assign m_we_n_o  = req & s_we_n_i[win];
  assign m_wdata_o = req ? s_wdata_i[int'(win)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign m_be_o    = req ? s_be_i[int'(win)*BE_W +: BE_W] : '0;
  assign m_id_o    = req ? {win, s_id_i[int'(win)*ID_WIDTH +: ID_WIDTH]} : '0;
  assign s_gnt_o   = hs ? NB_REQ'(1) << win : '0;
  // Responses for unknown requesters or empty counters are dropped and flagged.
  assign r_idx       = m_r_id_i[IDX_W+ID_WIDTH-1:ID_WIDTH];
  assign r_ok        = m_r_valid_i && (int'(r_idx) < NB_REQ) && (outst_q[r_idx] != '0);
  assign s_r_valid_o = r_ok ? NB_REQ'(1) << r_idx : '0;
  assign s_r_id_o    = m_r_id_i[ID_WIDTH-1:0];
  assign s_r_opc_o   = m_r_opc_i;
  assign s_r_rdata_o = m_r_rdata_i;
  assign err_o       = err_q;
  always_comb begin
    busy_o = req;
    for (int k = 0; k < NB_REQ; k++) begin
      outst_d[k] = outst_q[k] + CNT_W'(hs && win == IDX_W'(k)) - CNT_W'(r_ok && r_idx == IDX_W'(k));
      busy_o     = busy_o | (outst_q[k] != '0);
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ARB;
      rr_q    <= '0;
      lock_q  <= '0;
      outst_q <= '{default: '0};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      lock_q  <= lock_d;
      outst_q <= outst_d;
      err_q   <= err_q | (m_r_valid_i & ~r_ok);
    end
  end
endmodule
